// File: rtl/prog_mem_pkg.sv
// ============================================================================
// prog_mem_pkg : shared types and constants for the Simple CPU program memory
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package prog_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Opcode occupies the top two bits of an 8-bit instruction, immediate the rest.
  localparam int          OPC_MSB = 7;
  localparam int          OPC_LSB = 6;
  localparam logic [1:0]  OPC_ADD = 2'b00;
  localparam logic [1:0]  OPC_SUB = 2'b01;
  localparam logic [1:0]  OPC_JMP = 2'b10;
  localparam logic [1:0]  OPC_NOP = 2'b11;

  localparam int          BOOT_PROG_LEN = 2;
  localparam logic [7:0]  BOOT_PROG [BOOT_PROG_LEN] = '{
    8'b00000011,   // ADD 3
    8'b10000000    // JMP 0
  };

endpackage : prog_mem_pkg

`default_nettype wire

// File: rtl/prog_mem_array.sv
// ============================================================================
// prog_mem_array : simple dual-port RAM, sync write, sync read, write-first.
// Optional even-parity bit per word when PROG_MEM_PARITY_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int BOOT_LEN   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  perr_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef PROG_MEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  typedef logic [MEM_W-1:0] word_t;
  typedef word_t            image_t [DEPTH];

  function automatic word_t encode(input logic [DATA_WIDTH-1:0] d);
`ifdef PROG_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  function automatic image_t boot_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < BOOT_LEN && i < BOOT_PROG_LEN)
        img[i] = encode(DATA_WIDTH'(BOOT_PROG[i]));
      else
        img[i] = encode('0);
    end
    return img;
  endfunction

  // Contents come from elaboration only; reset never touches the array.
  image_t                mem_q = boot_image();
  word_t                 byp_word;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    byp_word = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i))
      byp_word = encode(wdata_i);
  end

  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[waddr_i] <= encode(wdata_i);
  end

`ifdef PROG_MEM_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else if (re_i) begin
      rdata_q <= byp_word[DATA_WIDTH-1:0];
      perr_q  <= ^byp_word;
    end
  end

  assign perr_o = perr_q;
`else
  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else if (re_i)
      rdata_q <= byp_word[DATA_WIDTH-1:0];
  end

  assign perr_o = 1'b0;
`endif

  assign rdata_o = rdata_q;

endmodule : prog_mem_array

`default_nettype wire

// File: rtl/prog_mem.sv
// ============================================================================
// prog_mem : loadable instruction memory with 1-cycle fetch and ready/valid
// program-load port. Optional word parity via PROG_MEM_PARITY_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int BOOT_LEN   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  busy,
  output logic                  parity_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH:0]   load_count_q;
  logic                  instr_valid_q;
  logic                  load_ready_q;
  logic                  load_done_q;
  logic                  busy_q;
  logic                  we_d;
  logic                  re_d;
  logic                  perr;

  // A write coinciding with reset is dropped so an aborted load stops cleanly.
  assign we_d = (state_q == LOAD) && load_valid && !rst;
  assign re_d = (state_q == IDLE) && fetch_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      load_count_q  <= '0;
      instr_valid_q <= 1'b0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      instr_valid_q <= re_d;
      load_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q      <= LOAD;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            load_count_q <= load_count_q + 1'b1;
            if (load_last || (wr_ptr_q == LAST_ADDR)) begin
              state_q      <= DONE;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          load_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  prog_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BOOT_LEN   (BOOT_LEN)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_d),
    .waddr_i (wr_ptr_q),
    .wdata_i (load_data),
    .re_i    (re_d),
    .raddr_i (fetch_addr),
    .rdata_o (instruction),
    .perr_o  (perr)
  );

  assign instr_valid = instr_valid_q;
  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign load_count  = load_count_q;
  assign busy        = busy_q;
  assign parity_err  = perr & instr_valid_q;

endmodule : prog_mem

`default_nettype wire
